// File: rtl/conv_window_feeder_pkg.sv
// Shared CNN layer control types: window feeder FSM states and related typedefs.
package conv_window_feeder_pkg;

    typedef enum logic [0:0] {
        eFILL = 1'b0,
        eFULL = 1'b1
    } feeder_state_e;

    // Counter operation selected each cycle by the feeder control logic.
    typedef enum logic [1:0] {
        eCNT_HOLD  = 2'd0,
        eCNT_INC   = 2'd1,
        eCNT_DEC   = 2'd2,
        eCNT_CLEAR = 2'd3
    } fill_cnt_op_e;

endpackage

// File: rtl/conv_window_feeder_fill_counter.sv
// Fill counter for the window feeder: clear, increment, decrement or hold.
module window_fill_counter
    import conv_window_feeder_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 2,
    parameter int unsigned WIDTH     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    fill_cnt_op_e     op;

    always_comb begin
        op = eCNT_HOLD;
        if (clear_i) begin
            op = eCNT_CLEAR;
        end else if (inc_i && !dec_i) begin
            op = eCNT_INC;
        end else if (dec_i && !inc_i) begin
            op = eCNT_DEC;
        end
    end

    always_comb begin
        count_d = count_q;
        case (op)
            eCNT_CLEAR: count_d = '0;
            eCNT_INC:   count_d = count_q + WIDTH'(1);
            eCNT_DEC:   count_d = count_q - WIDTH'(1);
            default:    count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/conv_window_feeder.sv
// Buffers KERNEL_WIDTH input columns and presents them as a sliding window
// (stride 1) with a valid/ready input side and a valid/yumi output side.
module conv_window_feeder
    import conv_window_feeder_pkg::*;
#(
    parameter int unsigned INPUT_LAYER_HEIGHT = 4,
    parameter int unsigned KERNEL_WIDTH       = 2,
    parameter int unsigned WORD_SIZE          = 16
) (
    input  logic                                                         clk_i,
    input  logic                                                         reset_i,
    input  logic                                                         flush_i,
    input  logic                                                         valid_i,
    output logic                                                         ready_o,
    input  logic [INPUT_LAYER_HEIGHT-1:0][WORD_SIZE-1:0]                 data_i,
    output logic                                                         valid_o,
    input  logic                                                         yumi_i,
    output logic [INPUT_LAYER_HEIGHT-1:0][KERNEL_WIDTH-1:0][WORD_SIZE-1:0] data_o
);

    localparam int unsigned CW = $clog2(KERNEL_WIDTH + 1);

    logic [KERNEL_WIDTH-1:0][INPUT_LAYER_HEIGHT-1:0][WORD_SIZE-1:0] col_q;
    logic [KERNEL_WIDTH-1:0][INPUT_LAYER_HEIGHT-1:0][WORD_SIZE-1:0] col_d;
    feeder_state_e state_q;
    feeder_state_e state_d;
    logic [CW-1:0] count;
    logic          accept;
    logic          cnt_inc;
    logic          cnt_dec;

    assign ready_o = ~flush_i & ((state_q == eFILL) | yumi_i);
    assign valid_o = (state_q == eFULL);
    assign accept  = valid_i & ready_o;

    // In eFULL an accept always coincides with yumi, so the count only holds.
    assign cnt_inc = accept & (state_q == eFILL);
    assign cnt_dec = ~flush_i & (state_q == eFULL) & yumi_i & ~accept;

    window_fill_counter #(
        .MAX_COUNT (KERNEL_WIDTH),
        .WIDTH     (CW)
    ) u_fill_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (flush_i),
        .inc_i   (cnt_inc),
        .dec_i   (cnt_dec),
        .count_o (count)
    );

    always_comb begin
        col_d   = col_q;
        state_d = state_q;
        if (flush_i) begin
            state_d = eFILL;
        end else if (state_q == eFILL) begin
            if (accept) begin
                for (int unsigned k = 0; k < KERNEL_WIDTH; k++) begin
                    if (count == CW'(k)) begin
                        col_d[k] = data_i;
                    end
                end
                if (count == CW'(KERNEL_WIDTH - 1)) begin
                    state_d = eFULL;
                end
            end
        end else if (yumi_i) begin
            for (int unsigned k = 0; k + 1 < KERNEL_WIDTH; k++) begin
                col_d[k] = col_q[k+1];
            end
            if (accept) begin
                col_d[KERNEL_WIDTH-1] = data_i;
            end else begin
                state_d = eFILL;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_q   <= '0;
            state_q <= eFILL;
        end else begin
            col_q   <= col_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        for (int unsigned h = 0; h < INPUT_LAYER_HEIGHT; h++) begin
            for (int unsigned k = 0; k < KERNEL_WIDTH; k++) begin
                data_o[h][k] = col_q[k][h];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed and scoreboard checks of conv_window_feeder at KERNEL_WIDTH=2 and 1.
module tb_conv_window_feeder;

    typedef logic [3:0][15:0]        col_t;
    typedef logic [3:0][1:0][15:0]   win_t;
    typedef logic [3:0][0:0][15:0]   win1_t;

    logic  clk = 1'b0;
    logic  reset_i = 1'b0;
    logic  flush_i = 1'b0;
    logic  valid_i = 1'b0;
    logic  yumi_i = 1'b0;
    col_t  data_i = '0;
    logic  ready_o;
    logic  valid_o;
    win_t  data_o;

    logic  flush1 = 1'b0;
    logic  valid1 = 1'b0;
    logic  yumi1 = 1'b0;
    col_t  data1 = '0;
    logic  ready1_o;
    logic  valid1_o;
    win1_t data1_o;

    int tests = 0;
    int fails = 0;

    col_t A, B, C, D, E;

    always #5 clk = ~clk;

    conv_window_feeder #(
        .INPUT_LAYER_HEIGHT (4),
        .KERNEL_WIDTH       (2),
        .WORD_SIZE          (16)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .yumi_i  (yumi_i),
        .data_o  (data_o)
    );

    conv_window_feeder #(
        .INPUT_LAYER_HEIGHT (4),
        .KERNEL_WIDTH       (1),
        .WORD_SIZE          (16)
    ) dut1 (
        .clk_i   (clk),
        .reset_i (reset_i),
        .flush_i (flush1),
        .valid_i (valid1),
        .ready_o (ready1_o),
        .data_i  (data1),
        .valid_o (valid1_o),
        .yumi_i  (yumi1),
        .data_o  (data1_o)
    );

    function automatic col_t mk(input logic [15:0] a, b, c, d);
        col_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    function automatic win_t win2(input col_t o, input col_t n);
        win_t w;
        for (int h = 0; h < 4; h++) begin
            w[h][0] = o[h];
            w[h][1] = n[h];
        end
        return w;
    endfunction

    function automatic win1_t win1(input col_t x);
        win1_t w;
        for (int h = 0; h < 4; h++) w[h][0] = x[h];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; yumi_i = 1'b0;
        flush1 = 1'b0; valid1 = 1'b0; yumi1 = 1'b0;
        step();
        step();
        reset_i = 1'b0;
    endtask

    task automatic send(input col_t c);
        valid_i = 1'b1;
        data_i  = c;
        step();
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        tests++;
        if (data_o !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", data_o); end
        tests++;
        if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        tests++;
        if (valid1_o !== 1'b0 || data1_o !== '0) begin
            fails++; $display("FAIL reset_k1: got valid %b data %h expected 0/0", valid1_o, data1_o);
        end
    endtask

    task automatic test_fill_hold();
        do_reset();
        send(A);
        tests++;
        if (valid_o !== 1'b0) begin fails++; $display("FAIL fill_after_A: got valid %b expected 0", valid_o); end
        send(B);
        tests++;
        if (valid_o !== 1'b1) begin fails++; $display("FAIL fill_after_B: got valid %b expected 1", valid_o); end
        tests++;
        if (data_o !== win2(A, B)) begin fails++; $display("FAIL fill_window: got %h expected %h", data_o, win2(A, B)); end
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== win2(A, B)) begin
                fails++;
                $display("FAIL hold_cycle%0d: got ready %b valid %b data %h expected 0/1/%h",
                         i, ready_o, valid_o, data_o, win2(A, B));
            end
        end
    endtask

    task automatic test_back_to_back();
        col_t cols [6];
        int n;
        int k;
        logic acc;
        cols[0] = A; cols[1] = B; cols[2] = C;
        cols[3] = mk(13, 14, 15, 16); cols[4] = mk(17, 18, 19, 20); cols[5] = mk(21, 22, 23, 24);
        do_reset();
        n = 0;
        k = 0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            valid_i = (n < 6);
            if (n < 6) data_i = cols[n];
            yumi_i = valid_o;
            #1;
            acc = valid_i & ready_o;
            if (valid_i) begin
                tests++;
                if (ready_o !== 1'b1) begin fails++; $display("FAIL stream_ready c%0d: got %b expected 1", cyc, ready_o); end
            end
            @(posedge clk);
            #1;
            if (acc) n++;
            if (valid_o === 1'b1) begin
                if (k < 5) begin
                    tests++;
                    if (data_o !== win2(cols[k], cols[k+1])) begin
                        fails++;
                        $display("FAIL stream_win%0d: got %h expected %h", k, data_o, win2(cols[k], cols[k+1]));
                    end
                end
                k++;
            end
        end
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        tests++;
        if (k != 5) begin fails++; $display("FAIL stream_count: got %0d windows expected 5", k); end
    endtask

    task automatic test_yumi_alone();
        do_reset();
        send(A);
        send(B);
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        tests++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            fails++; $display("FAIL yumi_alone: got valid %b ready %b expected 0/1", valid_o, ready_o);
        end
        send(C);
        tests++;
        if (valid_o !== 1'b1 || data_o !== win2(B, C)) begin
            fails++; $display("FAIL yumi_then_C: got valid %b data %h expected 1/%h", valid_o, data_o, win2(B, C));
        end
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        tests++;
        if (valid_o !== 1'b0) begin fails++; $display("FAIL yumi_drain: got valid %b expected 0", valid_o); end
    endtask

    task automatic test_flush();
        do_reset();
        send(A);
        flush_i = 1'b1;
        valid_i = 1'b1;
        data_i  = B;
        #1;
        tests++;
        if (ready_o !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b expected 0", ready_o); end
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        tests++;
        if (valid_o !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", valid_o); end
        send(D);
        tests++;
        if (valid_o !== 1'b0) begin fails++; $display("FAIL flush_after_D: got valid %b expected 0", valid_o); end
        send(E);
        tests++;
        if (valid_o !== 1'b1 || data_o !== win2(D, E)) begin
            fails++; $display("FAIL flush_window: got valid %b data %h expected 1/%h", valid_o, data_o, win2(D, E));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(A);
        send(B);
        reset_i = 1'b1;
        yumi_i  = 1'b1;
        step();
        reset_i = 1'b0;
        yumi_i  = 1'b0;
        tests++;
        if (valid_o !== 1'b0 || data_o !== '0) begin
            fails++; $display("FAIL reset_mid: got valid %b data %h expected 0/0", valid_o, data_o);
        end
        send(D);
        tests++;
        if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_mid_D: got valid %b expected 0", valid_o); end
        send(E);
        tests++;
        if (valid_o !== 1'b1 || data_o !== win2(D, E)) begin
            fails++; $display("FAIL reset_mid_window: got valid %b data %h expected 1/%h", valid_o, data_o, win2(D, E));
        end
    endtask

    task automatic test_k1();
        logic  full_m;
        col_t  win_m;
        logic  exp_ready;
        logic  acc;
        col_t  x;
        do_reset();
        x = mk(16'h00aa, 16'h00bb, 16'h00cc, 16'h00dd);
        valid1 = 1'b1;
        data1  = x;
        step();
        valid1 = 1'b0;
        tests++;
        if (valid1_o !== 1'b1 || data1_o !== win1(x)) begin
            fails++; $display("FAIL k1_single: got valid %b data %h expected 1/%h", valid1_o, data1_o, win1(x));
        end
        full_m = 1'b1;
        win_m  = x;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            valid1 = 1'($urandom_range(0, 1));
            data1  = {$urandom(), $urandom()};
            yumi1  = full_m & 1'($urandom_range(0, 1));
            #1;
            exp_ready = ~full_m | yumi1;
            tests++;
            if (ready1_o !== exp_ready) begin
                fails++; $display("FAIL k1_ready c%0d: got %b expected %b", cyc, ready1_o, exp_ready);
            end
            acc = valid1 & exp_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                full_m = 1'b1;
                win_m  = data1;
            end else if (yumi1) begin
                full_m = 1'b0;
            end
            tests++;
            if (valid1_o !== full_m || (full_m && data1_o !== win1(win_m))) begin
                fails++;
                $display("FAIL k1_window c%0d: got valid %b data %h expected %b/%h",
                         cyc, valid1_o, data1_o, full_m, win1(win_m));
            end
        end
        valid1 = 1'b0;
        yumi1  = 1'b0;
    endtask

    initial begin
        A = mk(1, 2, 3, 4);
        B = mk(5, 6, 7, 8);
        C = mk(9, 10, 11, 12);
        D = mk(16'h0d00, 16'h0d01, 16'h0d02, 16'h0d03);
        E = mk(16'h0e00, 16'h0e01, 16'h0e02, 16'h0e03);
        test_reset();
        test_fill_hold();
        test_back_to_back();
        test_yumi_alone();
        test_flush();
        test_reset_mid();
        test_k1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
